gmii_rx_frame_gen: RTL and testbench
====================================

Name: gmii_rx_frame_gen

Overview:
- Synthesizable GMII receive-side frame generator. Drives gmii_rxd/gmii_rx_dv/gmii_rx_er into the LMAC RX path. Replaces fixed idle stimulus with configurable frame bursts.
- Builds preamble, SFD, a seeded incrementing payload and a real Ethernet FCS, followed by an inter-frame gap.
- Adds frame count, continuous mode and error injection (bad FCS, rx_er, truncation) for on-board and simulation regression of the 1G LMAC.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes before SFD (1..15)
LEN_W, 14, width of cfg_len
CNT_W, 16, width of cfg_count and frame_cnt
IFG_MIN, 12, minimum inter-frame gap in cycles
ERR_POS, 20, payload byte index (0-based) that gets gmii_rx_er in error mode 2

Ports:
lclk  in  1  125 MHz LMAC clock
rst  in  1  asynchronous active-high reset
cfg_start  in  1  one-cycle start pulse
cfg_stop  in  1  one-cycle stop request
cfg_len  in  LEN_W  payload bytes per frame, FCS excluded
cfg_seed  in  8  first payload byte
cfg_count  in  CNT_W  frames to send; 0 = continuous
cfg_ifg  in  8  requested gap in cycles
cfg_err_mode  in  2  0 none, 1 bad FCS, 2 rx_er at ERR_POS, 3 truncate
gmii_rxd  out  8  GMII data
gmii_rx_dv  out  1  GMII data valid
gmii_rx_er  out  1  GMII error
busy  out  1  high from the cycle after start through the end of the last IFG
done  out  1  one-cycle pulse at burst end
frame_cnt  out  CNT_W  frames emitted since the last start

Behaviour:
- Reset values:
  - gmii_rxd = 8'h07, gmii_rx_dv = 0, gmii_rx_er = 0.
  - busy = 0, done = 0, frame_cnt = 0.
  - State = IDLE.
- All outputs are registered.
- State machine: IDLE -> PRE -> SFD -> DATA -> FCS -> IFG -> (PRE | IDLE).
- IDLE:
  - Outputs hold their reset values.
  - If cfg_start = 1 at edge k, all cfg_* inputs are latched and frame_cnt clears to 0.
  - The first 0x55 appears with dv = 1 at edge k+1.
  - cfg_start in any other state is ignored.
  - cfg_stop in IDLE is ignored, including when it coincides with cfg_start.
- PRE: PREAMBLE_LEN cycles of 0x55 with dv = 1.
- SFD: one cycle of 0xD5 with dv = 1.
- DATA:
  - Latched length L = max(cfg_len, 1).
  - Byte i = (seed + i) mod 256, wrapping 0xFF -> 0x00.
  - No padding is added.
- FCS:
  - 4 cycles. CRC-32 over the payload bytes only: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - Sent least-significant byte first.
  - frame_cnt increments on the last FCS cycle and wraps at 2^CNT_W.
- Wire frame length = PREAMBLE_LEN + 1 + L + 4 cycles of dv = 1, back to back with no bubbles.
- IFG:
  - max(latched cfg_ifg, IFG_MIN) cycles with dv = 0, er = 0, rxd = 0x07.
  - At the end of IFG: if cfg_count != 0 and frame_cnt == cfg_count, or a stop is pending, go to IDLE. Otherwise go to PRE.
- done:
  - Pulses for 1 cycle on the IDLE-entry cycle after a burst.
  - busy falls on that same cycle.
- cfg_stop while busy:
  - Sets a stop-pending flag.
  - The current frame and its IFG complete normally, then the block goes to IDLE with a done pulse.
- Error modes (apply to every frame of the burst):
  - 1: the last FCS byte is bitwise inverted.
  - 2: gmii_rx_er = 1 with dv = 1 for the single DATA cycle i = ERR_POS. If ERR_POS >= L, no error is injected.
  - 3: dv drops after floor(L/2) data bytes, then go straight to IFG with no FCS. The frame still increments frame_cnt. L = 1 gives zero data bytes: SFD is followed directly by IFG.
- cfg_* changes while busy have no effect until the next start.
- rst asserted mid-frame: all outputs return to reset values immediately (asynchronous), with no partial FCS.

Test Plan:
- Reset mid-DATA at frame byte 5 -> gmii_rx_dv = 0 and gmii_rxd = 0x07 in the same cycle; busy = 0, frame_cnt = 0; a restart produces a clean frame.
- cfg_len = 9, seed = 0x31, count = 1, mode 0 -> 7x55, D5, 31..39, then 26 39 F4 CB; 21 dv cycles; 12 IFG cycles; done at cycle 34 after start; frame_cnt = 1.
- Same setup, mode 1 -> FCS bytes 26 39 F4 34. Mode 3 -> dv high for 12 cycles (7+1+4), no FCS.
- cfg_len = 64, seed = 0xF0, count = 3, cfg_ifg = 4 -> payload wraps FF -> 00 at byte 15; gaps are 12 cycles (clamped); frame_cnt = 3; single done pulse.
- cfg_len = 60, mode 2, count = 0, stop pulsed during frame 2 DATA -> er high only on payload byte 20 of each frame; frame 2 completes with FCS plus IFG, then IDLE; frame_cnt = 2; start pulses while busy are ignored.

Source files
------------

// File: rtl/gmii_rx_frame_gen_if.sv
// Configuration, GMII and status bundle for the RX frame generator.
// master = generator side, slave = controller / GMII consumer side.
interface gmii_rx_frame_gen_if #(
  parameter int LEN_W = 14,
  parameter int CNT_W = 16
);
  logic             cfg_start;
  logic             cfg_stop;
  logic [LEN_W-1:0] cfg_len;
  logic [7:0]       cfg_seed;
  logic [CNT_W-1:0] cfg_count;
  logic [7:0]       cfg_ifg;
  logic [1:0]       cfg_err_mode;
  logic [7:0]       gmii_rxd;
  logic             gmii_rx_dv;
  logic             gmii_rx_er;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    input  cfg_start, cfg_stop, cfg_len, cfg_seed, cfg_count, cfg_ifg, cfg_err_mode,
    output gmii_rxd, gmii_rx_dv, gmii_rx_er, busy, done, frame_cnt
  );

  modport slave (
    output cfg_start, cfg_stop, cfg_len, cfg_seed, cfg_count, cfg_ifg, cfg_err_mode,
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er, busy, done, frame_cnt
  );
endinterface

// File: rtl/gmii_rx_frame_gen.sv
// GMII receive-side frame generator: preamble, SFD, incrementing payload, CRC-32 FCS and IFG,
// with burst count, continuous mode, stop request and error injection.
module gmii_rx_frame_gen #(
  parameter int PREAMBLE_LEN = 7,
  parameter int LEN_W        = 14,
  parameter int CNT_W        = 16,
  parameter int IFG_MIN      = 12,
  parameter int ERR_POS      = 20
) (
  input  logic               lclk,
  input  logic               rst,
  gmii_rx_frame_gen_if.master bus
);
  // state | meaning
  // IDLE  | waiting for cfg_start, outputs at idle values
  // PRE   | preamble bytes 0x55
  // SFD   | start-of-frame delimiter 0xD5
  // DATA  | seeded incrementing payload
  // FCS   | four CRC-32 bytes, LSB first
  // IFG   | inter-frame gap, then next frame or IDLE
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_FCS  = 3'd4;
  localparam logic [2:0] S_IFG  = 3'd5;

  localparam int CW = (LEN_W > 8) ? LEN_W : 8;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++) begin
      r = {1'b0, r[31:1]} ^ (r[0] ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       ifg_q, ifg_d;
  logic [7:0]       seed_q, seed_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       mode_q, mode_d;
  logic             stop_q, stop_d;
  logic [7:0]       data_q, data_d;
  logic [LEN_W-1:0] didx_q, didx_d;
  logic [31:0]      crc_q, crc_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]       rxd_q, rxd_d;
  logic             dv_q, dv_d;
  logic             er_q, er_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] nbytes;
  logic [CW-1:0]    ifg_load;

  assign nbytes   = (mode_q == 2'd3) ? (len_q >> 1) : len_q;
  assign ifg_load = CW'(ifg_q) - CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    ifg_d       = ifg_q;
    seed_d      = seed_q;
    count_d     = count_q;
    mode_d      = mode_q;
    stop_d      = stop_q;
    data_d      = data_q;
    didx_d      = didx_q;
    crc_d       = crc_q;
    frame_cnt_d = frame_cnt_q;

    if (state_q != S_IDLE && bus.cfg_stop) stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.cfg_start) begin
          state_d     = S_PRE;
          cnt_d       = CW'(PREAMBLE_LEN - 1);
          len_d       = (bus.cfg_len == '0) ? LEN_W'(1) : bus.cfg_len;
          ifg_d       = (bus.cfg_ifg < 8'(IFG_MIN)) ? 8'(IFG_MIN) : bus.cfg_ifg;
          seed_d      = bus.cfg_seed;
          count_d     = bus.cfg_count;
          mode_d      = bus.cfg_err_mode;
          stop_d      = 1'b0;
          data_d      = bus.cfg_seed;
          didx_d      = '0;
          crc_d       = 32'hFFFFFFFF;
          frame_cnt_d = '0;
        end
      end
      S_PRE: begin
        if (cnt_q == '0) state_d = S_SFD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_SFD: begin
        // truncation of a one-byte frame leaves no payload at all
        if (nbytes == '0) begin
          state_d     = S_IFG;
          cnt_d       = ifg_load;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end else begin
          state_d = S_DATA;
          cnt_d   = CW'(nbytes - LEN_W'(1));
        end
      end
      S_DATA: begin
        data_d = data_q + 8'd1;
        didx_d = didx_q + LEN_W'(1);
        crc_d  = crc_byte(crc_q, data_q);
        if (cnt_q == '0) begin
          if (mode_q == 2'd3) begin
            state_d     = S_IFG;
            cnt_d       = ifg_load;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end else begin
            state_d = S_FCS;
            cnt_d   = CW'(3);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FCS: begin
        crc_d = {8'h00, crc_q[31:8]};
        if (cnt_q == '0) begin
          state_d     = S_IFG;
          cnt_d       = ifg_load;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_IFG: begin
        if (cnt_q == '0) begin
          if ((count_q != '0 && frame_cnt_q == count_q) || stop_q || bus.cfg_stop) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_PRE;
            cnt_d   = CW'(PREAMBLE_LEN - 1);
            data_d  = seed_q;
            didx_d  = '0;
            crc_d   = 32'hFFFFFFFF;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // GMII outputs are registered from the current state, so they trail it by one cycle
  always_comb begin
    rxd_d  = 8'h07;
    dv_d   = 1'b0;
    er_d   = 1'b0;
    busy_d = (state_q != S_IDLE);
    done_d = (state_q == S_IDLE) && busy_q;
    case (state_q)
      S_PRE: begin
        rxd_d = 8'h55;
        dv_d  = 1'b1;
      end
      S_SFD: begin
        rxd_d = 8'hD5;
        dv_d  = 1'b1;
      end
      S_DATA: begin
        rxd_d = data_q;
        dv_d  = 1'b1;
        er_d  = (mode_q == 2'd2) && (didx_q == LEN_W'(ERR_POS));
      end
      S_FCS: begin
        rxd_d = ((mode_q == 2'd1) && (cnt_q == '0)) ? crc_q[7:0] : ~crc_q[7:0];
        dv_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge lclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      ifg_q       <= '0;
      seed_q      <= '0;
      count_q     <= '0;
      mode_q      <= '0;
      stop_q      <= 1'b0;
      data_q      <= '0;
      didx_q      <= '0;
      crc_q       <= 32'hFFFFFFFF;
      frame_cnt_q <= '0;
      rxd_q       <= 8'h07;
      dv_q        <= 1'b0;
      er_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ifg_q       <= ifg_d;
      seed_q      <= seed_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      stop_q      <= stop_d;
      data_q      <= data_d;
      didx_q      <= didx_d;
      crc_q       <= crc_d;
      frame_cnt_q <= frame_cnt_d;
      rxd_q       <= rxd_d;
      dv_q        <= dv_d;
      er_q        <= er_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.gmii_rxd   = rxd_q;
  assign bus.gmii_rx_dv = dv_q;
  assign bus.gmii_rx_er = er_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_gmii_rx_frame_gen.sv
// Scoreboard bench for gmii_rx_frame_gen: a frame-level model queues the expected per-cycle
// GMII/status observations and a monitor compares every cycle in which the generator is active.
module tb_gmii_rx_frame_gen;
  localparam int PRE     = 7;
  localparam int LEN_W   = 14;
  localparam int CNT_W   = 16;
  localparam int IFG_MIN = 12;
  localparam int ERR_POS = 20;

  logic lclk = 1'b0;
  logic rst  = 1'b1;
  always #4 lclk = ~lclk;

  gmii_rx_frame_gen_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  gmii_rx_frame_gen #(
    .PREAMBLE_LEN(PRE), .LEN_W(LEN_W), .CNT_W(CNT_W), .IFG_MIN(IFG_MIN), .ERR_POS(ERR_POS)
  ) dut (
    .lclk(lclk),
    .rst (rst),
    .bus (bus)
  );

  // {busy, done, dv, er, rxd}
  logic [11:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input bit b, input bit d, input bit v, input bit e,
                               input logic [7:0] x);
    exp_q.push_back({b, d, v, e, x});
  endfunction

  function automatic logic [31:0] crc_ref(input logic [7:0] p[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (p[i]) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ p[i][k]) c = (c >> 1) ^ 32'hEDB88320;
        else                c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic model_burst(input int len, input int seed, input int nframes,
                             input int ifg, input int mode);
    int L, gap, nb;
    logic [7:0] pl[$];
    logic [31:0] crc;
    logic [7:0] b;
    L   = (len == 0) ? 1 : len;
    gap = (ifg < IFG_MIN) ? IFG_MIN : ifg;
    for (int i = 0; i < L; i++) pl.push_back(8'((seed + i) % 256));
    crc = crc_ref(pl);
    nb  = (mode == 3) ? L / 2 : L;
    for (int f = 0; f < nframes; f++) begin
      repeat (PRE) push(1, 0, 1, 0, 8'h55);
      push(1, 0, 1, 0, 8'hD5);
      for (int i = 0; i < nb; i++) push(1, 0, 1, (mode == 2) && (i == ERR_POS), pl[i]);
      if (mode != 3) begin
        for (int j = 0; j < 4; j++) begin
          b = crc[8*j +: 8];
          if (mode == 1 && j == 3) b = ~b;
          push(1, 0, 1, 0, b);
        end
      end
      repeat (gap) push(1, 0, 0, 0, 8'h07);
    end
    push(0, 1, 0, 0, 8'h07);
  endtask

  always @(negedge lclk) begin
    logic [11:0] e;
    if (!rst && (bus.busy || bus.done)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %0h expected no activity",
                 {bus.busy, bus.done, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rxd});
      end else begin
        e = exp_q.pop_front();
        chk("gmii_cycle", {20'h0, bus.busy, bus.done, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rxd},
            {20'h0, e});
      end
    end
  end

  task automatic start_burst(input int len, input int seed, input int count,
                             input int ifg, input int mode);
    @(negedge lclk);
    bus.cfg_len      = LEN_W'(len);
    bus.cfg_seed     = 8'(seed);
    bus.cfg_count    = CNT_W'(count);
    bus.cfg_ifg      = 8'(ifg);
    bus.cfg_err_mode = 2'(mode);
    bus.cfg_start    = 1'b1;
    @(negedge lclk);
    bus.cfg_start    = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge lclk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d pending entries expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge lclk);
  endtask

  task automatic run_burst(input string name, input int len, input int seed, input int count,
                           input int ifg, input int mode);
    model_burst(len, seed, count, ifg, mode);
    start_burst(len, seed, count, ifg, mode);
    drain(name);
    chk({name, "_frame_cnt"}, 32'(bus.frame_cnt), 32'(count));
    chk({name, "_busy_end"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    int len, seed, cnt, ifg, mode;
    bus.cfg_start    = 1'b0;
    bus.cfg_stop     = 1'b0;
    bus.cfg_len      = '0;
    bus.cfg_seed     = '0;
    bus.cfg_count    = '0;
    bus.cfg_ifg      = '0;
    bus.cfg_err_mode = '0;

    #20;
    chk("reset_rxd", 32'(bus.gmii_rxd), 32'h07);
    chk("reset_dv", 32'(bus.gmii_rx_dv), 32'h0);
    chk("reset_er", 32'(bus.gmii_rx_er), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    chk("reset_frame_cnt", 32'(bus.frame_cnt), 32'h0);
    @(negedge lclk);
    rst = 1'b0;
    repeat (2) @(negedge lclk);

    run_burst("basic_mode0", 9, 'h31, 1, 0, 0);
    run_burst("bad_fcs", 9, 'h31, 1, 0, 1);
    run_burst("truncate", 9, 'h31, 1, 0, 3);
    run_burst("truncate_len1", 1, 'hA0, 2, 0, 3);
    run_burst("len0_as_1", 0, 'h10, 1, 13, 0);
    run_burst("wrap_clamp", 64, 'hF0, 3, 4, 0);

    // continuous burst, stop during frame 2, foreign starts while busy
    model_burst(60, 'h5A, 2, 0, 2);
    start_burst(60, 'h5A, 0, 0, 2);
    repeat (50) @(posedge lclk);
    @(negedge lclk);
    bus.cfg_len      = LEN_W'(5);
    bus.cfg_count    = CNT_W'(1);
    bus.cfg_seed     = 8'h00;
    bus.cfg_err_mode = 2'd0;
    bus.cfg_start    = 1'b1;
    @(negedge lclk);
    bus.cfg_start    = 1'b0;
    repeat (60) @(posedge lclk);
    @(negedge lclk);
    bus.cfg_stop = 1'b1;
    bus.cfg_start = 1'b1;
    @(negedge lclk);
    bus.cfg_stop = 1'b0;
    bus.cfg_start = 1'b0;
    drain("stop_cont");
    chk("stop_cont_frame_cnt", 32'(bus.frame_cnt), 32'd2);
    bus.cfg_stop = 1'b1;
    @(negedge lclk);
    bus.cfg_stop = 1'b0;
    repeat (3) @(negedge lclk);
    chk("stop_idle_ignored", 32'(bus.busy), 32'h0);

    // async reset at frame 2 payload byte 5
    model_burst(10, 'h77, 2, 0, 0);
    start_burst(10, 'h77, 2, 0, 0);
    repeat (48) @(posedge lclk);
    #1;
    chk("pre_reset_byte5", 32'({bus.gmii_rx_dv, bus.gmii_rxd}), 32'h17C);
    chk("pre_reset_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_dv", 32'(bus.gmii_rx_dv), 32'h0);
    chk("rst_async_rxd", 32'(bus.gmii_rxd), 32'h07);
    chk("rst_async_busy", 32'(bus.busy), 32'h0);
    chk("rst_async_frame_cnt", 32'(bus.frame_cnt), 32'h0);
    @(negedge lclk);
    exp_q.delete();
    @(negedge lclk);
    rst = 1'b0;
    repeat (2) @(negedge lclk);
    run_burst("after_reset", 12, 'h00, 1, 15, 1);

    for (int r = 0; r < 12; r++) begin
      len  = $urandom_range(0, 40);
      seed = $urandom_range(0, 255);
      cnt  = $urandom_range(1, 3);
      ifg  = $urandom_range(0, 20);
      mode = $urandom_range(0, 3);
      run_burst("random", len, seed, cnt, ifg, mode);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
